onewire_slave: RTL

- 1-wire bus responder (slave): the device end of the protocol driven by the SoC 1-wire master.
- Detects bus resets and answers each with a presence pulse.
- Decodes master write slots into received bytes and drives read slots from a loaded transmit byte, LSB first.
- Used as an on-FPGA slave on a spare pin (PS2/GPIO) for master loopback tests and device emulation.

---
 rtl/onewire_pkg.sv | 26 ++
 rtl/onewire_sync.sv | 39 +++
 rtl/onewire_slave.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/onewire_pkg.sv
// Shared 1-wire definitions: slave FSM states and default bus timing in microseconds.
package onewire_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SLOT,
      ST_RWAIT,
      ST_PDLY,
      ST_PRES,
      ST_PEND
   } state_e;

   localparam int unsigned CLK_FRQ_DEF = 24_000_000;
   localparam int unsigned T_GLT_DEF   = 1;
   localparam int unsigned T_SMP_DEF   = 30;
   localparam int unsigned T_DRV_DEF   = 45;
   localparam int unsigned T_RST_DEF   = 400;
   localparam int unsigned T_PDL_DEF   = 30;
   localparam int unsigned T_PRS_DEF   = 120;

   // Converts a time in microseconds to clock cycles.
   function automatic int unsigned us_to_cyc(input int unsigned clk_frq, input int unsigned t_us);
      return t_us * (clk_frq / 1_000_000);
   endfunction

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchronizer for a 1-wire pad, idle-high, with falling-edge detect and a
// one-cycle-early falling-edge lookahead.
module onewire_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic async_i,
   output logic lvl_o,
   output logic fall_c,
   output logic fall_nxt_c
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic prev_q, prev_d;

   always_comb begin
      s1_d   = async_i;
      s2_d   = s1_q;
      prev_d = s2_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
      end
   end

   assign lvl_o      = s2_q;
   assign fall_c     = prev_q & ~s2_q;
   // The edge that fall_c will report on the next cycle is already visible one stage back.
   assign fall_nxt_c = s2_q & ~s1_q;

endmodule

// File: rtl/onewire_slave.sv
// 1-wire slave: answers bus resets with presence, decodes write slots into bytes and
// drives read slots from a loaded byte, LSB first.
module onewire_slave
   import onewire_pkg::*;
#(
   parameter int unsigned CLK_FRQ = CLK_FRQ_DEF,
   parameter int unsigned T_GLT   = T_GLT_DEF,
   parameter int unsigned T_SMP   = T_SMP_DEF,
   parameter int unsigned T_DRV   = T_DRV_DEF,
   parameter int unsigned T_RST   = T_RST_DEF,
   parameter int unsigned T_PDL   = T_PDL_DEF,
   parameter int unsigned T_PRS   = T_PRS_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       owr_i,
   output logic       owr_e,
   output logic [7:0] rx_dat,
   output logic       rx_vld,
   input  logic [7:0] tx_dat,
   input  logic       tx_vld,
   output logic       tx_rdy,
   output logic       rst_det,
   output logic       busy
);

   localparam int unsigned GLT_CYC = us_to_cyc(CLK_FRQ, T_GLT);
   localparam int unsigned SMP_CYC = us_to_cyc(CLK_FRQ, T_SMP);
   localparam int unsigned DRV_CYC = us_to_cyc(CLK_FRQ, T_DRV);
   localparam int unsigned RST_CYC = us_to_cyc(CLK_FRQ, T_RST);
   localparam int unsigned PDL_CYC = us_to_cyc(CLK_FRQ, T_PDL);
   localparam int unsigned PRS_CYC = us_to_cyc(CLK_FRQ, T_PRS);
   localparam int unsigned CW      = $clog2(RST_CYC + 1);

   logic bus_lvl, fall_c, fall_nxt_c;

   onewire_sync u_sync (
      .clk        (clk),
      .reset_n    (reset_n),
      .async_i    (owr_i),
      .lvl_o      (bus_lvl),
      .fall_c     (fall_c),
      .fall_nxt_c (fall_nxt_c)
   );

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic          mode_q, mode_d;
   logic          tx_full_q, tx_full_d;
   logic [7:0]    tx_sh_q, tx_sh_d;
   logic [7:0]    rx_sh_q, rx_sh_d, rx_nxt;
   logic [7:0]    rx_dat_q, rx_dat_d;
   logic          rx_vld_q, rx_vld_d;
   logic          tx_rdy_q, tx_rdy_d;
   logic          rst_det_q, rst_det_d;
   logic          owr_e_q, owr_e_d;
   logic          busy_q, busy_d;

   // Next-state and output logic; mode_q is 1 for a transmit slot.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      mode_d    = mode_q;
      tx_full_d = tx_full_q;
      tx_sh_d   = tx_sh_q;
      rx_sh_d   = rx_sh_q;
      rx_nxt    = rx_sh_q;
      rx_dat_d  = rx_dat_q;
      rx_vld_d  = 1'b0;
      rst_det_d = 1'b0;
      owr_e_d   = owr_e_q;
      cnt_inc   = (cnt_q == CW'(RST_CYC)) ? cnt_q : cnt_q + CW'(1);

      if (tx_vld && tx_rdy_q) begin
         tx_sh_d   = tx_dat;
         tx_full_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (fall_c) begin
               state_d = ST_SLOT;
               cnt_d   = '0;
               mode_d  = tx_full_q;
               if (tx_full_q && !tx_sh_q[0]) owr_e_d = 1'b1;
            end
         end
         ST_SLOT: begin
            if (cnt_q == CW'(RST_CYC)) begin
               rst_det_d = 1'b1;
               owr_e_d   = 1'b0;
               bit_cnt_d = '0;
               tx_full_d = 1'b0;
               rx_sh_d   = '0;
               state_d   = ST_RWAIT;
            end else if (bus_lvl) begin
               owr_e_d = 1'b0;
               state_d = ST_IDLE;
               if (cnt_q >= CW'(GLT_CYC)) begin
                  // Released before the sample point: the sampled level is high.
                  if (!mode_q && cnt_q <= CW'(SMP_CYC)) rx_nxt = {1'b1, rx_sh_q[7:1]};
                  rx_sh_d   = rx_nxt;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (mode_q) tx_sh_d = {1'b0, tx_sh_q[7:1]};
                  if (bit_cnt_q == 3'd7) begin
                     if (mode_q) begin
                        tx_full_d = 1'b0;
                     end else begin
                        rx_dat_d = rx_nxt;
                        rx_vld_d = 1'b1;
                     end
                  end
               end
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CW'(DRV_CYC)) owr_e_d = 1'b0;
               if (!mode_q && cnt_q == CW'(SMP_CYC)) rx_sh_d = {1'b0, rx_sh_q[7:1]};
            end
         end
         ST_RWAIT: begin
            if (bus_lvl) begin
               state_d = ST_PDLY;
               cnt_d   = '0;
            end
         end
         ST_PDLY: begin
            if (cnt_q == CW'(PDL_CYC - 1)) begin
               state_d = ST_PRES;
               cnt_d   = '0;
               owr_e_d = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_PRES: begin
            if (cnt_q == CW'(PRS_CYC - 1)) begin
               state_d = ST_PEND;
               cnt_d   = '0;
               owr_e_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_PEND: begin
            if (fall_c) begin
               state_d = ST_SLOT;
               cnt_d   = '0;
               mode_d  = tx_full_q;
            end else if (bus_lvl) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d   = (state_d != ST_IDLE);
      // Dropping ready one cycle ahead of a falling edge keeps accepts out of the edge cycle.
      tx_rdy_d = (state_d == ST_IDLE) && !tx_full_d && (bit_cnt_d == 3'd0) && !fall_nxt_c;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         mode_q    <= 1'b0;
         tx_full_q <= 1'b0;
         tx_sh_q   <= '0;
         rx_sh_q   <= '0;
         rx_dat_q  <= '0;
         rx_vld_q  <= 1'b0;
         tx_rdy_q  <= 1'b1;
         rst_det_q <= 1'b0;
         owr_e_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         mode_q    <= mode_d;
         tx_full_q <= tx_full_d;
         tx_sh_q   <= tx_sh_d;
         rx_sh_q   <= rx_sh_d;
         rx_dat_q  <= rx_dat_d;
         rx_vld_q  <= rx_vld_d;
         tx_rdy_q  <= tx_rdy_d;
         rst_det_q <= rst_det_d;
         owr_e_q   <= owr_e_d;
         busy_q    <= busy_d;
      end
   end

   assign owr_e   = owr_e_q;
   assign rx_dat  = rx_dat_q;
   assign rx_vld  = rx_vld_q;
   assign tx_rdy  = tx_rdy_q;
   assign rst_det = rst_det_q;
   assign busy    = busy_q;

endmodule
